axi_lsu_slave: RTL

//  AXI-lite responder for the LSU data port: services loads (AR/R) and stores (AW/W/B) from the LSU-side master.

---
 rtl/axi_lsu_slave_pkg.sv | 38 +++
 rtl/axi_lsu_slave_mem.sv | 30 +++
 rtl/axi_lsu_slave.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lsu_slave_pkg.sv
// Shared response codes, FSM state types and width macros for the LSU data-port responder.
// LSU_SLV_WAIT_EN adds the R_WAIT read state.
`ifndef AXI_LSU_SLAVE_PKG_DEFS
`define AXI_LSU_SLAVE_PKG_DEFS
`define LSU_SLV_ADDR_W 32
`define LSU_SLV_DATA_W 64
`define LSU_SLV_RESP_W 2
`endif

package axi_lsu_slave_pkg;

   typedef logic [`LSU_SLV_RESP_W-1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

`ifdef LSU_SLV_WAIT_EN
   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } rd_state_e;
`else
   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;
`endif

   typedef enum logic [1:0] {
      W_IDLE,
      W_GOT_A,
      W_GOT_D,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axi_lsu_slave_mem.sv
// Word memory for the LSU responder: combinational read port, byte-strobed synchronous write port.
module axi_lsu_slave_mem #(
   parameter int DATA_W    = 64,
   parameter int MEM_DEPTH = 4096,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic                clk,
   input  logic [IDX_W-1:0]    raddr_i,
   output logic [DATA_W-1:0]   rdata_o,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   assign rdata_o = mem_q[raddr_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (wstrb_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/axi_lsu_slave.sv
// AXI-lite responder for the LSU data port with independent read and write FSMs.
// Define LSU_SLV_WAIT_EN to insert RD_WAIT extra cycles before each read response.
module axi_lsu_slave
   import axi_lsu_slave_pkg::*;
#(
   parameter int                ADDR_W    = `LSU_SLV_ADDR_W,
   parameter int                DATA_W    = `LSU_SLV_DATA_W,
   parameter int                MEM_DEPTH = 4096,
   parameter logic [ADDR_W-1:0] MEM_BASE  = 'h8000_0000,
   parameter int                RD_WAIT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   lsu_ar_addr,
   input  logic                lsu_ar_valid,
   output logic                lsu_ar_ready,
   output logic [DATA_W-1:0]   lsu_r_data,
   output logic [1:0]          lsu_r_resp,
   output logic                lsu_r_valid,
   input  logic                lsu_r_ready,
   input  logic [ADDR_W-1:0]   lsu_aw_addr,
   input  logic                lsu_aw_valid,
   output logic                lsu_aw_ready,
   input  logic [DATA_W-1:0]   lsu_w_data,
   input  logic [DATA_W/8-1:0] lsu_w_strb,
   input  logic                lsu_w_valid,
   output logic                lsu_w_ready,
   output logic [1:0]          lsu_b_resp,
   output logic                lsu_b_valid,
   input  logic                lsu_b_ready
);

   localparam int STRB_W = DATA_W/8;
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(MEM_DEPTH) << 3;

   if (((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) || (RD_WAIT < 0)) begin : g_param_err
      $error("axi_lsu_slave: MEM_DEPTH must be a power of 2 and RD_WAIT non-negative");
   end

   function automatic logic hit_f(input logic [ADDR_W-1:0] a);
      return (a >= MEM_BASE) && ({1'b0, a - MEM_BASE} < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] idx_f(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - MEM_BASE) >> 3);
   endfunction

   rd_state_e         rd_q, rd_d;
   logic [DATA_W-1:0] r_data_q, r_data_d;
   resp_t             r_resp_q, r_resp_d;
   logic              ar_ready_c, r_valid_c;

`ifdef LSU_SLV_WAIT_EN
   localparam int CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   wr_state_e         wr_q, wr_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   resp_t             b_resp_q, b_resp_d;
   logic              aw_ready_c, w_ready_c, b_valid_c, commit;

   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;
   logic [STRB_W-1:0] c_strb;
   logic              c_hit, ar_hit;
   logic [DATA_W-1:0] mem_rdata;

   assign ar_hit = hit_f(lsu_ar_addr);

   // Whichever half arrived earlier comes from its latch; the other half is live on the bus.
   assign c_addr = (wr_q == W_GOT_A) ? aw_addr_q : lsu_aw_addr;
   assign c_data = (wr_q == W_GOT_D) ? w_data_q  : lsu_w_data;
   assign c_strb = (wr_q == W_GOT_D) ? w_strb_q  : lsu_w_strb;
   assign c_hit  = hit_f(c_addr);

   axi_lsu_slave_mem #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_mem (
      .clk     (clk),
      .raddr_i (idx_f(lsu_ar_addr)),
      .rdata_o (mem_rdata),
      .we_i    (commit && c_hit),
      .waddr_i (idx_f(c_addr)),
      .wdata_i (c_data),
      .wstrb_i (c_strb)
   );

   always_comb begin
      rd_d       = rd_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      ar_ready_c = 1'b0;
      r_valid_c  = 1'b0;
`ifdef LSU_SLV_WAIT_EN
      cnt_d      = cnt_q;
`endif
      unique case (rd_q)
         R_IDLE: begin
            ar_ready_c = 1'b1;
            if (lsu_ar_valid) begin
               r_data_d = ar_hit ? mem_rdata : '0;
               r_resp_d = ar_hit ? RESP_OKAY : RESP_DECERR;
`ifdef LSU_SLV_WAIT_EN
               if (RD_WAIT == 0) begin
                  rd_d = R_DATA;
               end else begin
                  rd_d  = R_WAIT;
                  cnt_d = CNT_W'(RD_WAIT);
               end
`else
               rd_d = R_DATA;
`endif
            end
         end
`ifdef LSU_SLV_WAIT_EN
         R_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               rd_d = R_DATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         R_DATA: begin
            r_valid_c = 1'b1;
            if (lsu_r_ready) begin
               rd_d = R_IDLE;
            end
         end
         default: rd_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q     <= R_IDLE;
         r_data_q <= '0;
         r_resp_q <= RESP_OKAY;
`ifdef LSU_SLV_WAIT_EN
         cnt_q    <= '0;
`endif
      end else begin
         rd_q     <= rd_d;
         r_data_q <= r_data_d;
         r_resp_q <= r_resp_d;
`ifdef LSU_SLV_WAIT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      wr_d       = wr_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      b_resp_d   = b_resp_q;
      aw_ready_c = 1'b0;
      w_ready_c  = 1'b0;
      b_valid_c  = 1'b0;
      commit     = 1'b0;
      unique case (wr_q)
         W_IDLE: begin
            aw_ready_c = 1'b1;
            w_ready_c  = 1'b1;
            if (lsu_aw_valid && lsu_w_valid) begin
               commit = 1'b1;
            end else if (lsu_aw_valid) begin
               aw_addr_d = lsu_aw_addr;
               wr_d      = W_GOT_A;
            end else if (lsu_w_valid) begin
               w_data_d = lsu_w_data;
               w_strb_d = lsu_w_strb;
               wr_d     = W_GOT_D;
            end
         end
         W_GOT_A: begin
            w_ready_c = 1'b1;
            commit    = lsu_w_valid;
         end
         W_GOT_D: begin
            aw_ready_c = 1'b1;
            commit     = lsu_aw_valid;
         end
         W_RESP: begin
            b_valid_c = 1'b1;
            if (lsu_b_ready) begin
               wr_d = W_IDLE;
            end
         end
         default: wr_d = W_IDLE;
      endcase
      if (commit) begin
         wr_d     = W_RESP;
         b_resp_d = c_hit ? RESP_OKAY : RESP_DECERR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q      <= W_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_resp_q  <= RESP_OKAY;
      end else begin
         wr_q      <= wr_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         b_resp_q  <= b_resp_d;
      end
   end

   // Readies are forced low while reset is held, even though the FSMs already sit in IDLE.
   assign lsu_ar_ready = ar_ready_c && !rst;
   assign lsu_aw_ready = aw_ready_c && !rst;
   assign lsu_w_ready  = w_ready_c  && !rst;
   assign lsu_r_valid  = r_valid_c;
   assign lsu_b_valid  = b_valid_c;
   assign lsu_r_data   = r_data_q;
   assign lsu_r_resp   = r_resp_q;
   assign lsu_b_resp   = b_resp_q;

endmodule
